// File: rtl/reg_pkg.sv
// Shared definitions for the registered skid link: state encoding and occupancy decode.
package reg_pkg;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned OCC_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  // Entries held for a given state; the unused encoding reports empty.
  function automatic logic [OCC_W-1:0] occ_of(input state_t st);
    case (st)
      ST_BUSY: occ_of = OCC_W'(1);
      ST_FULL: occ_of = OCC_W'(2);
      default: occ_of = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/reg_skid_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_skid.sv
// Two-entry registered receive buffer (output reg + skid reg) with valid/ready on both sides.
// in_ready is a pure decode of the state flops, so no combinational path from out_ready.
module reg_skid
  import reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] skid_q;
  logic             load_out;
  logic             load_skid;
  logic             sel_skid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (in_valid && !out_ready)      state_d = ST_FULL;
        else if (!in_valid && out_ready) state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (out_ready) state_d = ST_BUSY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // Handshake decode and datapath load enables
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_out  = 1'b0;
    load_skid = 1'b0;
    sel_skid  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        in_ready = 1'b1;
        load_out = in_valid;
      end
      ST_BUSY: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        load_out  = in_valid && out_ready;
        load_skid = in_valid && !out_ready;
      end
      ST_FULL: begin
        out_valid = 1'b1;
        load_out  = out_ready;
        sel_skid  = 1'b1;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  assign occupancy = occ_of(state_q);

  // Data registers; contents behind a flushed state are don't-care
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      skid_q   <= '0;
    end else begin
      if (load_out)  out_data <= sel_skid ? skid_q : in_data;
      if (load_skid) skid_q   <= in_data;
    end
  end

  sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (out_valid && !out_ready),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_reg_skid.sv
// Scoreboard bench for reg_skid: directed scenarios followed by random traffic,
// checked against a queue-based model of a two-entry FIFO with a saturating stall count.
module tb_reg_skid;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;
  localparam int          STALL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words held, in order, and the stall count
  logic [WIDTH-1:0] exp_q[$];
  int               m_occ = 0;
  int               m_stall = 0;

  reg_skid #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge from the inputs that were stable over the cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_occ   = 0;
      m_stall = 0;
    end else begin
      bit acc, rel, stl;
      acc = in_valid && (m_occ < 2);
      rel = (m_occ > 0) && out_ready;
      stl = (m_occ > 0) && !out_ready;
      if (flush) begin
        exp_q.delete();
        m_occ   = 0;
        m_stall = 0;
      end else begin
        if (acc) exp_q.push_back(in_data);
        m_occ = m_occ + int'(acc) - int'(rel);
        if (stl && m_stall < STALL_MAX) m_stall = m_stall + 1;
      end
    end
  end

  // Monitor: status against the model, data popped on every output transfer
  always @(negedge clk) begin
    if (rst_n) begin
      check("occupancy", 32'(occupancy), 32'(m_occ));
      check("in_ready", 32'(in_ready), 32'(m_occ < 2));
      check("out_valid", 32'(out_valid), 32'(m_occ > 0));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_word: got 0x%0h with no word expected at %0t", out_data, $time);
        end else begin
          check("out_word", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) cyc(1'b1, WIDTH'(i), 1'b1, 1'b0);
    drain(2);

    // Back-pressure: 0xC waits upstream until space appears
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 32'hC, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_full_occ", 32'(occupancy), 32'd2);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    drain(3);

    // Flush while FULL with a word offered
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 32'h12, 1'b0, 1'b0);
    cyc(1'b1, 32'hD, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_stall", 32'(stall_cnt), 32'd0);

    // Flush from BUSY discards a word accepted in the same cycle
    cyc(1'b1, 32'h21, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b1, 1'b1);
    drain(2);

    // Stall counter saturation
    cyc(1'b1, 32'h55, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("sat_stall", 32'(stall_cnt), 32'(STALL_MAX));
    drain(2);
    @(negedge clk);
    check("sat_hold_after_release", 32'(stall_cnt), 32'(STALL_MAX));

    // Asynchronous reset mid-cycle while FULL
    cyc(1'b1, 32'h31, 1'b0, 1'b0);
    cyc(1'b1, 32'h32, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'h41, 1'b1, 1'b0);
    cyc(1'b1, 32'h42, 1'b1, 1'b0);
    drain(3);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom(),
          1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0));
    end
    drain(4);
    @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
